// File: rtl/instr_fetch_ctrl_pkg.sv
// rtl/instr_fetch_ctrl_pkg.sv - shared constants and types for the instruction fetch sequencer
package instr_fetch_ctrl_pkg;

    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
    localparam int          ENTRY_W       = 64;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_ctrl_fetch_queue.sv
// rtl/instr_fetch_ctrl_fetch_queue.sv - 2-entry FIFO of {pc, instr} fetch entries, flush beats push/pop
module instr_fetch_ctrl_fetch_queue
    import instr_fetch_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head_data,
    output logic [1:0]         count
);

    logic [ENTRY_W-1:0] slot0;
    logic [ENTRY_W-1:0] slot1;

    assign head_data = slot0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= push_data;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        slot1 <= push_data;
                        count <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count != 2'd0) begin
                        slot0 <= slot1;
                        count <= count - 2'd1;
                    end
                end
                2'b11: begin
                    // Pop on an empty queue cannot happen; treat it as a plain push.
                    if (count == 2'd0) begin
                        slot0 <= push_data;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        slot0 <= push_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - fetch PC sequencer with range fault, redirect and 2-deep decode queue
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_SIZE  = 8192,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    localparam logic [30:0] MEM_WORDS = 31'(MEM_SIZE);

    fetch_state_e       state;
    fetch_state_e       state_next;
    logic [31:0]        fetch_pc;
    logic [31:0]        fetch_pc_next;
    logic               fault_next;
    logic [31:0]        fault_pc_next;
    logic [1:0]         count;
    logic [ENTRY_W-1:0] head_data;
    fetch_entry_t       head;
    logic               in_range;
    logic               fire_pop;
    logic               fire_fetch;
    logic               unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign head       = fetch_entry_t'(head_data);
    assign in_range   = {1'b0, fetch_pc[31:2]} < MEM_WORDS;
    assign if_valid   = (count != 2'd0);
    assign fire_pop   = if_valid & id_ready;
    assign fire_fetch = (state == ST_RUN) & ~redirect_valid & in_range
                        & ((count < 2'd2) | fire_pop);

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        fault_next    = fetch_fault;
        fault_pc_next = fault_pc;
        if (redirect_valid) begin
            state_next    = ST_RUN;
            fetch_pc_next = {redirect_pc[31:2], 2'b00};
            fault_next    = 1'b0;
            fault_pc_next = 32'h0;
        end else if (state == ST_RUN) begin
            if (!in_range) begin
                state_next    = ST_FAULT;
                fault_next    = 1'b1;
                fault_pc_next = fetch_pc;
            end else if (fire_fetch) begin
                fetch_pc_next = fetch_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            fetch_pc    <= RESET_PC;
            fetch_fault <= 1'b0;
            fault_pc    <= 32'h0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            fetch_fault <= fault_next;
            fault_pc    <= fault_pc_next;
        end
    end

    // A redirect flushes the queue, dropping the word fetched this cycle.
    instr_fetch_ctrl_fetch_queue u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fire_fetch),
        .push_data ({fetch_pc, imem_instr}),
        .pop       (fire_pop),
        .head_data (head_data),
        .count     (count)
    );

    assign imem_pc  = fetch_pc;
    assign if_pc    = if_valid ? head.pc : 32'h0;
    assign if_instr = if_valid ? head.instr : NOP_INSTR;

endmodule
